// File: rtl/timer_sequencer.sv
// timer_sequencer: run-control FSM, count prescaler and ripple-carry digit
// enables for a chain of NDIG cascaded BCD up/down digit counters.

// Per-digit slice: terminal-value detect and gated advance enable.
module timer_seq_lane (
  input  logic [3:0] i_dig,
  input  logic       i_dir,
  input  logic       i_carry,  // every lower digit sits at its terminal value
  input  logic       i_adv,    // tick with the chain not yet at its final value
  output logic       o_term,
  output logic       o_en
);
  assign o_term = i_dir ? (i_dig == 4'd9) : (i_dig == 4'd0);
  assign o_en   = i_adv & i_carry;
endmodule

module timer_sequencer #(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 10
) (
  input  logic                Clk,
  input  logic                reset_n,
  input  logic                btn_start,
  input  logic                btn_pause,
  input  logic                btn_stop,
  input  logic                btn_set,
  input  logic                up_down,
  input  logic [4*NDIG-1:0]   dig_val,
  output logic [NDIG-1:0]     dig_en,
  output logic                dir,
  output logic                load,
  output logic                clear,
  output logic                tick,
  output logic                running,
  output logic                paused,
  output logic                done
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_PAUSED = 3'd2,
    S_DONE   = 3'd3,
    S_LOAD   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_START, C_PAUSE, C_SET, C_STOP
  } cmd_t;

  state_t          r_state;
  logic [PW-1:0]   r_psc;
  logic            r_dir, r_load, r_clear;
  cmd_t            w_cmd;
  logic            w_tick, w_final;
  logic [NDIG-1:0] w_term, w_carry;

  // Collapse simultaneous buttons to the single winning command.
  always_comb begin
    w_cmd = C_NONE;
    if      (btn_stop)  w_cmd = C_STOP;
    else if (btn_set)   w_cmd = C_SET;
    else if (btn_pause) w_cmd = C_PAUSE;
    else if (btn_start) w_cmd = C_START;
  end

  assign w_tick  = (r_state == S_RUN) && (r_psc == PSC_MAX);
  assign w_final = &w_term;

  // Ripple-carry: digit g advances only when all lower digits are terminal.
  for (genvar g = 0; g < NDIG; g++) begin : g_lane
    if (g == 0) begin : g_c0
      assign w_carry[g] = 1'b1;
    end else begin : g_cn
      assign w_carry[g] = &w_term[g-1:0];
    end
    timer_seq_lane u_lane (
      .i_dig   (dig_val[4*g +: 4]),
      .i_dir   (r_dir),
      .i_carry (w_carry[g]),
      .i_adv   (w_tick & ~w_final),
      .o_term  (w_term[g]),
      .o_en    (dig_en[g])
    );
  end

  // Run-state FSM with prescaler, latched direction and load/clear pulses.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_psc   <= '0;
      r_dir   <= 1'b1;
      r_load  <= 1'b0;
      r_clear <= 1'b0;
    end else begin
      r_load  <= 1'b0;
      r_clear <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd == C_STOP) begin
            r_clear <= 1'b1;
            r_psc   <= '0;
          end else if (w_cmd == C_SET) begin
            r_state <= S_LOAD;
            r_load  <= 1'b1;
          end else if (w_cmd == C_START) begin
            r_state <= S_RUN;
            r_dir   <= up_down;
            r_psc   <= '0;
          end
        end
        S_RUN: begin
          if (w_cmd == C_STOP) begin
            r_state <= S_IDLE;
            r_clear <= 1'b1;
            r_psc   <= '0;
          end else if (w_cmd == C_PAUSE) begin
            // Phase freezes here so resume picks up where it left off.
            r_state <= S_PAUSED;
          end else begin
            r_psc <= (r_psc == PSC_MAX) ? '0 : r_psc + 1'b1;
            if (w_tick && w_final) r_state <= S_DONE;
          end
        end
        S_PAUSED: begin
          if (w_cmd == C_STOP) begin
            r_state <= S_IDLE;
            r_clear <= 1'b1;
            r_psc   <= '0;
          end else if (w_cmd == C_SET) begin
            r_state <= S_LOAD;
            r_load  <= 1'b1;
          end else if (w_cmd == C_START) begin
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          if (w_cmd == C_STOP) begin
            r_state <= S_IDLE;
            r_clear <= 1'b1;
            r_psc   <= '0;
          end else if (w_cmd == C_SET) begin
            r_state <= S_LOAD;
            r_load  <= 1'b1;
          end
        end
        S_LOAD:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tick    = w_tick;
  assign dir     = r_dir;
  assign load    = r_load;
  assign clear   = r_clear;
  assign running = (r_state == S_RUN);
  assign paused  = (r_state == S_PAUSED);
  assign done    = (r_state == S_DONE);
endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: NDIG=2, PRESCALE=4, with a behavioural BCD digit
// chain closing the loop and a tick scoreboard (cycle, digit value, enables).
module tb_timer_sequencer;
  localparam int NDIG     = 2;
  localparam int PRESCALE = 4;

  localparam logic [3:0] B_START = 4'b0001;
  localparam logic [3:0] B_PAUSE = 4'b0010;
  localparam logic [3:0] B_SET   = 4'b0100;
  localparam logic [3:0] B_STOP  = 4'b1000;

  logic            Clk = 1'b0, reset_n = 1'b0;
  logic            btn_start = 1'b0, btn_pause = 1'b0, btn_stop = 1'b0, btn_set = 1'b0;
  logic            up_down = 1'b1;
  logic [7:0]      dig_val = 8'h00;
  logic [7:0]      init_val = 8'h00;
  logic [NDIG-1:0] dig_en;
  logic            dir, load, clear, tick, running, paused, done;

  int errors = 0, checks = 0, cyc = 0;
  int k, m;

  typedef struct { int cyc; logic [7:0] val; logic [1:0] en; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  timer_sequencer #(.NDIG(NDIG), .PRESCALE(PRESCALE)) dut (
    .Clk(Clk), .reset_n(reset_n),
    .btn_start(btn_start), .btn_pause(btn_pause), .btn_stop(btn_stop), .btn_set(btn_set),
    .up_down(up_down), .dig_val(dig_val), .dig_en(dig_en), .dir(dir),
    .load(load), .clear(clear), .tick(tick),
    .running(running), .paused(paused), .done(done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Digit chain: mod-10 up/down counters with clear and load.
  always @(posedge Clk) begin
    if (clear) dig_val <= 8'h00;
    else if (load) dig_val <= init_val;
    else for (int i = 0; i < NDIG; i++)
      if (dig_en[i])
        dig_val[4*i +: 4] <= dir ? ((dig_val[4*i +: 4] == 4'd9) ? 4'd0 : dig_val[4*i +: 4] + 4'd1)
                                 : ((dig_val[4*i +: 4] == 4'd0) ? 4'd9 : dig_val[4*i +: 4] - 4'd1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    {btn_stop, btn_set, btn_pause, btn_start} = b;
    step(1);
    {btn_stop, btn_set, btn_pause, btn_start} = 4'b0000;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic wait_empty(input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) step(1);
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic push(input int c, input logic [7:0] v, input logic [1:0] e);
    exp_t x;
    x.cyc = c; x.val = v; x.en = e;
    sb.push_back(x);
  endtask

  // Scoreboard: every tick must be expected; enables stay low between ticks.
  always @(negedge Clk) begin
    if (tick) begin
      if (sb.size() == 0) chk("spurious_tick", 32'(sb.size()), 32'd1);
      else begin
        mon_e = sb.pop_front();
        chk("tick_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("tick_val", 32'(dig_val), 32'(mon_e.val));
        chk("tick_en", 32'(dig_en), 32'(mon_e.en));
      end
    end else chk("en_no_tick", 32'(dig_en), 32'd0);
  end

  initial begin
    // Reset state
    #12;
    chk("rst_running", 32'(running), 0); chk("rst_paused", 32'(paused), 0);
    chk("rst_done", 32'(done), 0);       chk("rst_dir", 32'(dir), 1);
    chk("rst_load", 32'(load), 0);       chk("rst_clear", 32'(clear), 0);
    chk("rst_tick", 32'(tick), 0);       chk("rst_en", 32'(dig_en), 0);
    @(negedge Clk) reset_n = 1'b1;
    step(2);

    // Load 00 then count up to 99 and stop there
    init_val = 8'h00;
    press(B_SET);
    chk("ld_pulse", 32'(load), 1);
    step(1);
    chk("ld_low", 32'(load), 0); chk("ld_val", 32'(dig_val), 32'h00);
    up_down = 1'b1;
    press(B_START); k = cyc;
    chk("up_running", 32'(running), 1); chk("up_dir", 32'(dir), 1);
    for (int n = 0; n < 100; n++)
      push(k + 3 + 4*n, bcd(n), (n == 99) ? 2'b00 : ((n % 10 == 9) ? 2'b11 : 2'b01));
    wait_empty(500);
    chk("up_done", 32'(done), 1); chk("up_stopped", 32'(running), 0);
    chk("up_final", 32'(dig_val), 32'h99);
    step(6);
    chk("up_done_held", 32'(done), 1); chk("up_nowrap", 32'(dig_val), 32'h99);

    // Load 10 then count down to 00
    init_val = 8'h10;
    press(B_SET);
    chk("ld2_pulse", 32'(load), 1);
    step(1);
    chk("ld2_val", 32'(dig_val), 32'h10); chk("ld2_done_off", 32'(done), 0);
    up_down = 1'b0;
    press(B_START); k = cyc;
    chk("dn_dir", 32'(dir), 0);
    for (int n = 0; n <= 10; n++)
      push(k + 3 + 4*n, bcd(10 - n), (n == 10) ? 2'b00 : (((10 - n) % 10 == 0) ? 2'b11 : 2'b01));
    wait_empty(100);
    chk("dn_done", 32'(done), 1); chk("dn_final", 32'(dig_val), 32'h00);
    step(5);
    chk("dn_nowrap", 32'(dig_val), 32'h00);

    // Pause at psc=1, idle 20 cycles with up_down toggled, resume
    init_val = 8'h00;
    press(B_SET); step(1);
    up_down = 1'b1;
    press(B_START); k = cyc;
    push(k + 3, 8'h00, 2'b01);
    wait_cyc(k + 5);
    press(B_PAUSE);
    chk("ps_paused", 32'(paused), 1); chk("ps_notrun", 32'(running), 0);
    up_down = 1'b0;
    step(20);
    chk("ps_held", 32'(paused), 1); chk("ps_val", 32'(dig_val), 32'h01);
    press(B_START); m = cyc;
    chk("rs_running", 32'(running), 1); chk("rs_dir", 32'(dir), 1);
    push(m + 2, 8'h01, 2'b01);
    push(m + 6, 8'h02, 2'b01);
    push(m + 10, 8'h03, 2'b01);
    wait_empty(40);

    // Stop+set+start together in RUN: stop wins
    press(B_STOP | B_SET | B_START);
    chk("pr_notrun", 32'(running), 0); chk("pr_clear", 32'(clear), 1);
    chk("pr_noload", 32'(load), 0);
    step(1);
    chk("pr_clear_off", 32'(clear), 0); chk("pr_noload2", 32'(load), 0);
    chk("pr_cleared", 32'(dig_val), 32'h00);
    chk("pr_idle", 32'({running, paused, done}), 0);
    init_val = 8'h42;
    press(B_SET);
    chk("pr_load", 32'(load), 1);
    step(1);
    chk("pr_load_off", 32'(load), 0); chk("pr_idle2", 32'({running, paused, done}), 0);
    chk("pr_loaded", 32'(dig_val), 32'h42);

    // Async reset mid-RUN during a tick cycle
    up_down = 1'b0;
    press(B_START); k = cyc;
    push(k + 3, 8'h42, 2'b01);
    push(k + 7, 8'h41, 2'b01);
    wait_cyc(k + 7);
    @(negedge Clk); #2;
    chk("ar_pre_en", 32'(dig_en), 32'b01); chk("ar_pre_dir", 32'(dir), 0);
    reset_n = 1'b0;
    #1;
    chk("ar_running", 32'(running), 0); chk("ar_en", 32'(dig_en), 0);
    chk("ar_tick", 32'(tick), 0);       chk("ar_dir", 32'(dir), 1);
    chk("ar_clear", 32'(clear), 0);     chk("ar_flags", 32'({paused, done, load}), 0);
    step(3);
    @(negedge Clk) reset_n = 1'b1;
    step(10);
    chk("ar_stays_idle", 32'(running), 0); chk("ar_val", 32'(dig_val), 32'h41);
    press(B_START); k = cyc;
    chk("ar_restart", 32'(running), 1); chk("ar_restart_dir", 32'(dir), 0);
    push(k + 3, 8'h41, 2'b01);
    wait_empty(20);
    press(B_STOP);
    step(2);
    chk("end_sb", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/timer_sequencer.md
# timer_sequencer

Run-control sequencer for a chain of `NDIG` cascaded BCD digit counters (mod-10, up/down) forming a multi-digit timer. Decodes single-cycle button commands into a run-state FSM. Generates the prescaled count tick and issues per-digit advance enables with ripple-carry gating. Detects the terminal count (all-9 up, all-0 down) and stops the chain there. Sits between the button/debounce front end and the digit-counter datapath.

## Interface
- `NDIG`, 4: number of cascaded digits, range 1–8.
- `PRESCALE`, 10: `Clk` cycles per count tick, at least 2.
- `Clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_start`  in  1  single-cycle pulse; start or resume.
- `btn_pause`  in  1  single-cycle pulse; pause.
- `btn_stop`  in  1  single-cycle pulse; abort, return to idle.
- `btn_set`  in  1  single-cycle pulse; load initial values into the digits.
- `up_down`  in  1  1 = count up, 0 = count down; sampled only at start from IDLE.
- `dig_val`  in  4*NDIG  current digit values; digit i is at `[4i+3:4i]`, digit 0 is the least significant.
- `dig_en`  out  NDIG  per-digit advance enable; one cycle wide.
- `dir`  out  1  latched count direction, driven to all digits.
- `load`  out  1  one-cycle pulse; digits load their initial values.
- `clear`  out  1  one-cycle pulse; digits clear to 0.
- `tick`  out  1  one-cycle count tick; asserted only in RUN.
- `running`, `paused`, `done`  out  1 each  state flags.

## Operation
- The FSM has five states, encoded as 3 bits: IDLE=0, RUN=1, PAUSED=2, DONE=3, LOAD=4.
- Command priority when several are asserted in the same cycle: stop > set > pause > start. Only the highest-priority command acts; the others are dropped.
- IDLE transitions:
  - start → RUN. Latch `dir <= up_down` and clear the prescaler.
  - set → LOAD.
  - pause and stop → no state change. Stop still pulses `clear`.
- RUN transitions:
  - pause → PAUSED.
  - stop → IDLE.
  - set is ignored.
  - terminal tick → DONE (defined below).
- PAUSED transitions:
  - start → RUN. Prescaler phase is preserved; `dir` is not re-sampled.
  - set → LOAD.
  - stop → IDLE.
- DONE transitions:
  - set → LOAD.
  - stop → IDLE.
  - start and pause are ignored.
- LOAD: `load` is high for exactly that cycle, then unconditionally → IDLE. Buttons arriving during LOAD are ignored.
- Stop from any state pulses `clear` for one cycle (the cycle after the command) and clears the prescaler.
- Prescaler `psc`:
  - Counts 0..PRESCALE-1 only in RUN; wraps to 0.
  - Holds its value in PAUSED.
  - Zeroed on RUN entry from IDLE and on stop.
- `tick = (state==RUN) && (psc==PRESCALE-1)`; this is combinational from registers.
- Terminal digit value: 9 if `dir`=1, 0 if `dir`=0. `term_i` = (digit i is at its terminal value).
- `final` = all `term_i` are true.
- `dig_en[0] = tick & ~final`.
- `dig_en[i] = tick & ~final & term_0 & … & term_(i-1)`.
- A tick with `final` true issues no enables; the state goes to DONE at that edge. The timer never wraps past all-9 or all-0.
- Flags:
  - `running` = (state==RUN).
  - `paused` = (state==PAUSED).
  - `done` = (state==DONE); it is a level, held until set or stop.
- Digit values above 9 are treated as non-terminal; the digits are expected to self-correct.

## Timing
- Reset (asynchronous, `reset_n`=0):
  - State = IDLE, `psc`=0, `dir`=1.
  - All outputs 0 except `dir`.
  - Effective immediately, including mid-RUN; no `clear` pulse is generated.
- Commands are registered and take effect on the edge that samples them. Flags change the cycle after the button pulse.
- RUN entered at edge k: `psc`=0 during cycle k. The first `tick` and `dig_en` appear in cycle k+PRESCALE-1, and the digits update at edge k+PRESCALE. Ticks then repeat every PRESCALE cycles.
- Pause sampled in the same cycle as a tick: pause wins. State → PAUSED and no enable is issued, because `tick` is gated by state at the next cycle. The enables already visible in that cycle still occur.
- Resume with `psc`=p: the next tick arrives PRESCALE-1-p cycles after RUN re-entry.
- `dig_val` is sampled combinationally in the tick cycle. The digits must present their updated values within one cycle after each enable.

## Test plan
- Basic run: NDIG=2, PRESCALE=4, digits 00, set `up_down`=1, start.
  - Required: `dig_en`=01 every 4 cycles.
  - At value 09, the next tick gives `dig_en`=11; the value becomes 10.
  - At 99, the next tick gives no enable; `done`=1 in the following cycle.
- Down count: digits 10, `up_down`=0, start.
  - First tick: `dig_en`=11; the value becomes 09.
  - At 00, the next tick gives DONE, `done`=1, with no wrap to 99.
- Pause/resume: pause 2 cycles after a tick (`psc`=1), wait 20 cycles, start.
  - Required: no `tick` while paused.
  - Next tick arrives 2 cycles after resume.
  - `dir` is unchanged even if `up_down` toggled during the pause.
- Priority: `btn_stop`, `btn_set` and `btn_start` in the same cycle while in RUN.
  - Required: → IDLE, one `clear` pulse, no `load`.
  - Then `btn_set`: `load` is high one cycle, state is back in IDLE the next cycle.
- Async reset: assert `reset_n`=0 mid-RUN, halfway between clock edges.
  - Required: all flags and `dig_en` drop to 0 before the next edge, and `dir`=1.
  - After release, `btn_start` is needed to run again.
